// File: rtl/ram_arb.sv
// -----------------------------------------------------------------------------
// ram_arb -- two-port arbiter in front of a single-port synchronous RAM.
//
// Port A (CPU) and port B (DMA/display) share one memory port. Grants are
// combinational, so an access is accepted in the same cycle it is requested.
// Port A normally wins contention. Port B counts the contention cycles it
// loses, and once that count reaches MAX_WAIT it wins the next contention.
// Writes reach the memory in the accept cycle. Read data comes back one cycle
// later, tagged with the x_rvalid of the port that issued the read.
//
// Parameters
//   ADR_W     byte-address width of both ports and of the memory port
//   MAX_WAIT  lost contention cycles before port B gets priority (1..255)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   a_req/a_wr/a_be         port A request, write(1)/read(0), byte(1)/word(0)
//   a_adr/a_wdata           port A byte address and write data
//   a_ack                   port A access accepted this cycle
//   a_rvalid/a_rdata        port A read data (a_rdata is zero unless valid)
//   b_*                     the same signals for port B
//   mem_wr/mem_be           memory write strobe, byte access
//   mem_adr/mem_wdata       memory byte address and write data
//   mem_rdata               memory read data, valid one clk after the address
// -----------------------------------------------------------------------------
module ram_arb #(
  parameter int ADR_W    = 18,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // port A (CPU)
  input  logic             a_req,
  input  logic             a_wr,
  input  logic             a_be,
  input  logic [ADR_W-1:0] a_adr,
  input  logic [31:0]      a_wdata,
  output logic             a_ack,
  output logic             a_rvalid,
  output logic [31:0]      a_rdata,
  // port B (DMA/display)
  input  logic             b_req,
  input  logic             b_wr,
  input  logic             b_be,
  input  logic [ADR_W-1:0] b_adr,
  input  logic [31:0]      b_wdata,
  output logic             b_ack,
  output logic             b_rvalid,
  output logic [31:0]      b_rdata,
  // memory port
  output logic             mem_wr,
  output logic             mem_be,
  output logic [ADR_W-1:0] mem_adr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic {
    A_PRI = 1'b0,
    B_PRI = 1'b1
  } pri_e;

  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  pri_e       state_q, state_d;
  logic [7:0] b_wait_q, b_wait_d;
  logic       a_rvalid_q, b_rvalid_q;
  logic       grant_a, grant_b;

  // Grant, wait counter and priority next-state.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    b_wait_d = b_wait_q;
    state_d  = state_q;

    // rst_n gates the grants directly. That keeps acks and mem_wr low for the
    // whole reset and drops them the moment reset asserts, without waiting
    // for a clock edge.
    if (rst_n) begin
      if (a_req && (!b_req || state_q == A_PRI)) begin
        grant_a = 1'b1;
      end else if (b_req) begin
        grant_b = 1'b1;
      end
    end

    // Count only the cycles B asks and loses. Saturate at MAX_WAIT.
    if (grant_b) begin
      b_wait_d = 8'd0;
    end else if (b_req && b_wait_q != MAX_W8) begin
      b_wait_d = b_wait_q + 8'd1;
    end

    // The switch to B_PRI takes effect in the cycle after the count reaches
    // MAX_WAIT. Priority returns to A right after B is served.
    unique case (state_q)
      A_PRI: if (b_wait_d == MAX_W8) state_d = B_PRI;
      B_PRI: if (grant_b)            state_d = A_PRI;
      default:                       state_d = A_PRI;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= A_PRI;
      b_wait_q   <= 8'd0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      b_wait_q   <= b_wait_d;
      a_rvalid_q <= grant_a & ~a_wr;
      b_rvalid_q <= grant_b & ~b_wr;
    end
  end

  assign a_ack     = grant_a;
  assign b_ack     = grant_b;

  // The memory port follows B only when B is granted. Otherwise it follows A,
  // and when A is idle no strobe is raised.
  assign mem_adr   = grant_b ? b_adr   : a_adr;
  assign mem_be    = grant_b ? b_be    : a_be;
  assign mem_wdata = grant_b ? b_wdata : a_wdata;
  assign mem_wr    = (grant_a & a_wr) | (grant_b & b_wr);

  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rvalid_q ? mem_rdata : 32'h0;
  assign b_rdata   = b_rvalid_q ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_ram_arb -- directed self-checking bench for ram_arb (ADR_W=18, MAX_WAIT=4).
// Inputs change on the falling edge. Outputs are checked 1 ns later, so each
// window runs from one falling edge to the next and holds exactly one rising
// edge. The bench models the memory as a registered lookup of mem_adr.
// -----------------------------------------------------------------------------
module tb_ram_arb;

  localparam int ADR_W = 18;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a_req, a_wr, a_be, b_req, b_wr, b_be;
  logic [ADR_W-1:0] a_adr, b_adr;
  logic [31:0]      a_wdata, b_wdata;
  logic             a_ack, a_rvalid, b_ack, b_rvalid;
  logic [31:0]      a_rdata, b_rdata;
  logic             mem_wr, mem_be;
  logic [ADR_W-1:0] mem_adr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata = 32'h0;

  int total = 0;
  int bad   = 0;

  ram_arb #(.ADR_W(ADR_W), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_be(a_be), .a_adr(a_adr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_be(b_be), .b_adr(b_adr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_wr(mem_wr), .mem_be(mem_be), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory read contents as the bench knows them.
  function automatic logic [31:0] mem_val(input logic [ADR_W-1:0] adr);
    if (adr == 18'h010)      return 32'h1111_1111;
    else if (adr == 18'h020) return 32'h2222_2222;
    else                     return 32'hA5A5_0000 | {14'h0, adr};
  endfunction

  // Registered BRAM: data for the address of one cycle appears in the next.
  always @(posedge clk) mem_rdata <= mem_val(mem_adr);

  task automatic idle_all();
    a_req = 1'b0; a_wr = 1'b0; a_be = 1'b0; a_adr = '0; a_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_be = 1'b0; b_adr = '0; b_wdata = '0;
  endtask

  task automatic drive_a(input logic wr, input logic be,
                         input logic [ADR_W-1:0] adr, input logic [31:0] wd);
    a_req = 1'b1; a_wr = wr; a_be = be; a_adr = adr; a_wdata = wd;
  endtask

  task automatic drive_b(input logic wr, input logic be,
                         input logic [ADR_W-1:0] adr, input logic [31:0] wd);
    b_req = 1'b1; b_wr = wr; b_be = be; b_adr = adr; b_wdata = wd;
  endtask

  // Leaves the bench at a falling edge with reset just released and no requests.
  task automatic apply_reset();
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_a(1'b1, 1'b0, 18'h004, 32'h1);
    drive_b(1'b1, 1'b0, 18'h008, 32'h2);
    #1;
    total++;
    if ({a_ack, b_ack, mem_wr} !== 3'b000) begin
      bad++; $display("FAIL reset_acks: got a/b/wr=%b want 000", {a_ack, b_ack, mem_wr});
    end
    @(negedge clk); #1;
    total++;
    if ({a_ack, b_ack, mem_wr, a_rvalid, b_rvalid} !== 5'b00000) begin
      bad++; $display("FAIL reset_hold: got ack/wr/rv=%b want 00000",
                      {a_ack, b_ack, mem_wr, a_rvalid, b_rvalid});
    end
    @(negedge clk);
    idle_all();
    drive_a(1'b0, 1'b0, 18'h004, 32'h0);
    drive_b(1'b0, 1'b0, 18'h008, 32'h0);
    rst_n = 1'b1;
    #1;
    total++;
    if ({a_ack, b_ack} !== 2'b10) begin
      bad++; $display("FAIL reset_release_grant: got a/b=%b want 10", {a_ack, b_ack});
    end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_a_only();
    logic exp_ack, exp_rv;
    apply_reset();
    for (int c = 1; c <= 5; c++) begin
      idle_all();
      if (c <= 3) drive_a(1'b0, 1'b0, 18'h100, 32'h0);
      #1;
      exp_ack = (c <= 3);
      exp_rv  = (c >= 2 && c <= 4);
      total++;
      if ({a_ack, b_ack} !== {exp_ack, 1'b0}) begin
        bad++; $display("FAIL a_only_ack c%0d: got a/b=%b want %b", c, {a_ack, b_ack}, {exp_ack, 1'b0});
      end
      total++;
      if (a_rvalid !== exp_rv || a_rdata !== (exp_rv ? 32'hA5A5_0100 : 32'h0)) begin
        bad++; $display("FAIL a_only_rdata c%0d: got rv=%b %h want rv=%b %h", c, a_rvalid, a_rdata,
                        exp_rv, exp_rv ? 32'hA5A5_0100 : 32'h0);
      end
      if (c <= 3) begin
        total++;
        if (mem_adr !== 18'h100 || mem_wr !== 1'b0) begin
          bad++; $display("FAIL a_only_mem c%0d: got adr=%h wr=%b want 100 0", c, mem_adr, mem_wr);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    logic [11:0] pat;
    logic        bexp, prev_b;
    pat    = 12'h210;               // B wins in cycles 5 and 10 (bits 4 and 9)
    prev_b = 1'b0;
    apply_reset();
    drive_a(1'b0, 1'b0, 18'h040, 32'h0);
    drive_b(1'b0, 1'b0, 18'h080, 32'h0);
    for (int i = 0; i < 12; i++) begin
      #1;
      bexp = pat[i];
      total++;
      if ({a_ack, b_ack} !== {~bexp, bexp}) begin
        bad++; $display("FAIL contention_grant cyc%0d: got a/b=%b want %b", i + 1, {a_ack, b_ack}, {~bexp, bexp});
      end
      total++;
      if (mem_adr !== (bexp ? 18'h080 : 18'h040)) begin
        bad++; $display("FAIL contention_adr cyc%0d: got %h want %h", i + 1, mem_adr, bexp ? 18'h080 : 18'h040);
      end
      total++;
      if (b_rvalid !== prev_b || a_rvalid !== (i > 0 && !prev_b)) begin
        bad++; $display("FAIL contention_rvalid cyc%0d: got a/b=%b%b want %b%b", i + 1, a_rvalid, b_rvalid,
                        (i > 0 && !prev_b), prev_b);
      end
      prev_b = bexp;
      @(negedge clk);
    end
    idle_all();
  endtask

  task automatic test_write();
    apply_reset();
    drive_b(1'b1, 1'b1, 18'h203, 32'h0000_00AB);
    #1;
    total++;
    if ({b_ack, a_ack, mem_wr, mem_be} !== 4'b1011 || mem_adr !== 18'h203 || mem_wdata !== 32'hAB) begin
      bad++; $display("FAIL write_b: got ack b/a=%b%b wr=%b be=%b adr=%h wd=%h want 10 1 1 203 000000ab",
                      b_ack, a_ack, mem_wr, mem_be, mem_adr, mem_wdata);
    end
    @(negedge clk);
    idle_all();
    drive_a(1'b1, 1'b0, 18'h044, 32'hDEAD_BEEF);
    #1;
    total++;
    if ({a_ack, mem_wr, mem_be} !== 3'b110 || mem_adr !== 18'h044 || mem_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL write_a: got ack=%b wr=%b be=%b adr=%h wd=%h want 1 1 0 044 deadbeef",
                      a_ack, mem_wr, mem_be, mem_adr, mem_wdata);
    end
    total++;
    if (b_rvalid !== 1'b0) begin
      bad++; $display("FAIL write_b_norvalid: got %b want 0", b_rvalid);
    end
    @(negedge clk);
    idle_all();
    #1;
    total++;
    if ({a_rvalid, b_rvalid, mem_wr} !== 3'b000) begin
      bad++; $display("FAIL write_idle: got rv a/b wr=%b want 000", {a_rvalid, b_rvalid, mem_wr});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    drive_a(1'b0, 1'b0, 18'h010, 32'h0);
    #1;
    total++;
    if ({a_ack, b_ack} !== 2'b10) begin
      bad++; $display("FAIL b2b_c1_grant: got a/b=%b want 10", {a_ack, b_ack});
    end
    @(negedge clk);
    idle_all();
    drive_b(1'b0, 1'b0, 18'h020, 32'h0);
    #1;
    total++;
    if ({a_ack, b_ack} !== 2'b01 || mem_adr !== 18'h020) begin
      bad++; $display("FAIL b2b_c2_grant: got a/b=%b adr=%h want 01 020", {a_ack, b_ack}, mem_adr);
    end
    total++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'h1111_1111 || b_rvalid !== 1'b0 || b_rdata !== 32'h0) begin
      bad++; $display("FAIL b2b_c2_rdata: got a=%b/%h b=%b/%h want 1/11111111 0/00000000",
                      a_rvalid, a_rdata, b_rvalid, b_rdata);
    end
    @(negedge clk);
    idle_all();
    #1;
    total++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h2222_2222 || a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin
      bad++; $display("FAIL b2b_c3_rdata: got a=%b/%h b=%b/%h want 0/00000000 1/22222222",
                      a_rvalid, a_rdata, b_rvalid, b_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive_a(1'b0, 1'b0, 18'h010, 32'h0);
    drive_b(1'b1, 1'b0, 18'h030, 32'h55);
    for (int c = 1; c <= 4; c++) begin
      #1;
      total++;
      if ({a_ack, b_ack} !== 2'b10) begin
        bad++; $display("FAIL rstmid_pre c%0d: got a/b=%b want 10", c, {a_ack, b_ack});
      end
      @(negedge clk);
    end
    #1;
    total++;
    if ({b_ack, mem_wr, a_rvalid} !== 3'b111) begin
      bad++; $display("FAIL rstmid_bpri: got b_ack/wr/a_rv=%b want 111", {b_ack, mem_wr, a_rvalid});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_ack, b_ack, mem_wr, a_rvalid, b_rvalid} !== 5'b00000) begin
      bad++; $display("FAIL rstmid_assert: got ack/wr/rv=%b want 00000",
                      {a_ack, b_ack, mem_wr, a_rvalid, b_rvalid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({a_ack, b_ack, a_rvalid, b_rvalid} !== 4'b1000) begin
      bad++; $display("FAIL rstmid_release: got a/b ack rv=%b want 1000", {a_ack, b_ack, a_rvalid, b_rvalid});
    end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_idle_hold();
    apply_reset();
    for (int c = 1; c <= 10; c++) begin
      idle_all();
      if (c <= 3 || c >= 9) begin
        drive_a(1'b0, 1'b0, 18'h014, 32'h0);
        drive_b(1'b0, 1'b0, 18'h024, 32'h0);
      end
      #1;
      total++;
      if (c <= 3 || c == 9) begin
        if ({a_ack, b_ack} !== 2'b10) begin
          bad++; $display("FAIL idle_hold c%0d: got a/b=%b want 10", c, {a_ack, b_ack});
        end
      end else if (c == 10) begin
        if ({a_ack, b_ack} !== 2'b01) begin
          bad++; $display("FAIL idle_hold c%0d: got a/b=%b want 01", c, {a_ack, b_ack});
        end
      end else begin
        if ({a_ack, b_ack, mem_wr} !== 3'b000) begin
          bad++; $display("FAIL idle_hold c%0d: got a/b/wr=%b want 000", c, {a_ack, b_ack, mem_wr});
        end
      end
      @(negedge clk);
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_a_only();
    test_contention();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_idle_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
